// File: rtl/antisat_pkg.sv
// Shared types and helpers for the sequential Anti-SAT lock.
// key_t is a fixed-width container so the helpers serve any N up to MAX_N;
// callers zero-extend their N-bit values and pass N as the active width.
package antisat_pkg;

    localparam int MAX_N = 64;

    typedef logic [MAX_N-1:0] key_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT
    } state_t;

    // Locked-by-default key half: the low n bits are set to fill.
    // Use fill=1 for K1 (all ones) and fill=0 for K2 (all zeros).
    function automatic key_t default_key(input int n, input logic fill);
        key_t k;
        k = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) k[i] = fill;
        end
        return k;
    endfunction

    // Anti-SAT flip bit over the low n bits:
    // g = &(x ^ k1), g-bar = ~&(x ^ k2), signal = g & g-bar.
    // Equal key halves make g and &(x ^ k2) identical, so the signal is 0.
    function automatic logic antisat_sig(input key_t x, input key_t k1,
                                         input key_t k2, input int n);
        logic a;
        logic b;
        a = 1'b1;
        b = 1'b1;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                a = a & (x[i] ^ k1[i]);
                b = b & (x[i] ^ k2[i]);
            end
        end
        return a & ~b;
    endfunction

endpackage

// File: rtl/antisat_key_loader.sv
// Serial key loader for the Anti-SAT lock.
// Key bits are shifted into a shadow register (bit 0 first: K1 LSB..MSB,
// then K2 LSB..MSB) and only copied to the active key in a single COMMIT
// cycle, so a partial or aborted load never disturbs the active key.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for key_start; key_valid ignored
// ST_LOAD   | shifting key bits; key_start restarts the count
// ST_COMMIT | one cycle: shadow -> active key, key_loaded set
module antisat_key_loader
    import antisat_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_start,
    input  logic         key_bit,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         key_busy,
    output logic         key_loaded,
    output logic [N-1:0] k1,
    output logic [N-1:0] k2
);

    localparam int KW = 2 * N;
    localparam int CW = $clog2(KW);
    localparam logic [CW-1:0] LAST_BIT = CW'(KW - 1);
    localparam key_t K1_RST = default_key(N, 1'b1);
    localparam key_t K2_RST = default_key(N, 1'b0);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [KW-1:0]   shadow;

    // Key-load FSM with registered handshake flags and active key registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            shadow     <= '0;
            k1         <= K1_RST[N-1:0];
            k2         <= K2_RST[N-1:0];
            key_ready  <= 1'b1;
            key_busy   <= 1'b0;
            key_loaded <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_start) begin
                        state     <= ST_LOAD;
                        cnt       <= '0;
                        key_ready <= 1'b0;
                        key_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Restart wins over a coincident valid bit; old shadow
                    // bits are simply overwritten by the new load.
                    if (key_start) begin
                        cnt <= '0;
                    end else if (key_valid) begin
                        shadow[cnt] <= key_bit;
                        if (cnt == LAST_BIT) begin
                            cnt   <= '0;
                            state <= ST_COMMIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    k1         <= shadow[N-1:0];
                    k2         <= shadow[KW-1:N];
                    key_loaded <= 1'b1;
                    key_ready  <= 1'b1;
                    key_busy   <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    key_ready <= 1'b1;
                    key_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/antisat_seq_lock.sv
// Sequential Anti-SAT lock: serially loaded 2N-bit key, Anti-SAT flip bit
// computed from N primary inputs and XORed onto NCH protected nets.
// Build option ANTISAT_REG_OUT_EN registers sig_out/d_out (1-cycle latency,
// reset to 0); without it the output path is purely combinational.
module antisat_seq_lock
    import antisat_pkg::*;
#(
    parameter int N   = 8,
    parameter int NCH = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   x_in,
    input  logic [NCH-1:0] d_in,
    output logic [NCH-1:0] d_out,
    output logic           sig_out,
    input  logic           key_start,
    input  logic           key_bit,
    input  logic           key_valid,
    output logic           key_ready,
    output logic           key_busy,
    output logic           key_loaded
);

    logic [N-1:0]   k1;
    logic [N-1:0]   k2;
    logic           sig_comb;
    logic [NCH-1:0] d_comb;

    antisat_key_loader #(
        .N (N)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .key_start  (key_start),
        .key_bit    (key_bit),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_busy   (key_busy),
        .key_loaded (key_loaded),
        .k1         (k1),
        .k2         (k2)
    );

    assign sig_comb = antisat_sig(key_t'(x_in), key_t'(k1), key_t'(k2), N);
    assign d_comb   = d_in ^ {NCH{sig_comb}};

`ifdef ANTISAT_REG_OUT_EN
    // Registered output stage: one cycle behind x_in/d_in and the active key.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_out <= 1'b0;
            d_out   <= '0;
        end else begin
            sig_out <= sig_comb;
            d_out   <= d_comb;
        end
    end
`else
    assign sig_out = sig_comb;
    assign d_out   = d_comb;
`endif

endmodule

// File: tb/tb_antisat_seq_lock.sv
// Self-checking bench for antisat_seq_lock (N=8, NCH=4, combinational outputs).
module tb_antisat_seq_lock;

    localparam int N   = 8;
    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   x_in;
    logic [NCH-1:0] d_in;
    logic [NCH-1:0] d_out;
    logic           sig_out;
    logic           key_start;
    logic           key_bit;
    logic           key_valid;
    logic           key_ready;
    logic           key_busy;
    logic           key_loaded;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] x;
        logic [3:0] d;
        logic       exp_sig;
        logic [3:0] exp_d;
    } vec_t;

    vec_t vecs[6];

    antisat_seq_lock #(
        .N   (N),
        .NCH (NCH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x_in       (x_in),
        .d_in       (d_in),
        .d_out      (d_out),
        .sig_out    (sig_out),
        .key_start  (key_start),
        .key_bit    (key_bit),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_busy   (key_busy),
        .key_loaded (key_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_io(input logic [7:0] x, input logic [3:0] d);
        x_in = x;
        d_in = d;
        #1;
    endtask

    task automatic send_bit(input logic b);
        key_valid = 1'b1;
        key_bit   = b;
        tick();
        key_valid = 1'b0;
        key_bit   = 1'b0;
    endtask

    task automatic start_load();
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
    endtask

    // Shift all 16 bits (K1 LSB first, then K2); returns in the COMMIT cycle.
    task automatic shift_key(input logic [7:0] k1, input logic [7:0] k2);
        logic [15:0] kk;
        kk = {k2, k1};
        for (int i = 0; i < 16; i++) send_bit(kk[i]);
    endtask

    initial begin
        rst = 1'b1; x_in = '0; d_in = '0;
        key_start = 1'b0; key_bit = 1'b0; key_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state with the default (locked) key.
        set_io(8'h00, 4'hA);
        check("rst_sig", 32'(sig_out), 32'd1);
        check("rst_dout", 32'(d_out), 32'h5);
        check("rst_ready", 32'(key_ready), 32'd1);
        check("rst_busy", 32'(key_busy), 32'd0);
        check("rst_loaded", 32'(key_loaded), 32'd0);
        set_io(8'h01, 4'hA);
        check("rst_sig_x01", 32'(sig_out), 32'd0);

        // Equal key halves 5A/5A: signal never fires.
        start_load();
        check("load_busy", 32'(key_busy), 32'd1);
        check("load_ready", 32'(key_ready), 32'd0);
        shift_key(8'h5A, 8'h5A);
        set_io(8'h00, 4'hA);
        check("commit_old_key_sig", 32'(sig_out), 32'd1);
        check("commit_loaded", 32'(key_loaded), 32'd0);
        check("commit_busy", 32'(key_busy), 32'd1);
        tick();
        check("post_commit_loaded", 32'(key_loaded), 32'd1);
        check("post_commit_ready", 32'(key_ready), 32'd1);
        check("post_commit_busy", 32'(key_busy), 32'd0);
        for (int x = 0; x < 256; x++) begin
            set_io(8'(x), 4'(x));
            check("eq_sweep_sig", 32'(sig_out), 32'd0);
            check("eq_sweep_dout", 32'(d_out), 32'(x & 15));
        end

        // K1=00, K2=01: table-driven vectors.
        vecs[0] = '{8'hFF, 4'hA, 1'b1, 4'h5};
        vecs[1] = '{8'hFE, 4'hA, 1'b0, 4'hA};
        vecs[2] = '{8'h00, 4'h3, 1'b0, 4'h3};
        vecs[3] = '{8'hFF, 4'h0, 1'b1, 4'hF};
        vecs[4] = '{8'h01, 4'hC, 1'b0, 4'hC};
        vecs[5] = '{8'h7F, 4'h6, 1'b0, 4'h6};
        start_load();
        shift_key(8'h00, 8'h01);
        tick();
        for (int i = 0; i < 6; i++) begin
            set_io(vecs[i].x, vecs[i].d);
            check($sformatf("vec%0d_sig", i), 32'(sig_out), 32'(vecs[i].exp_sig));
            check($sformatf("vec%0d_dout", i), 32'(d_out), 32'(vecs[i].exp_d));
        end

        // Aborted load: 9 bits, restart, then 16 bits of 3C/3C.
        set_io(8'hFF, 4'h0);
        start_load();
        for (int i = 0; i < 9; i++) send_bit(1'b1);
        check("abort_old_key", 32'(sig_out), 32'd1);
        start_load();
        for (int i = 0; i < 15; i++) send_bit((16'h3C3C >> i) & 16'h1);
        check("abort_15_busy", 32'(key_busy), 32'd1);
        check("abort_15_old_key", 32'(sig_out), 32'd1);
        send_bit(1'b0);
        check("abort_commit_old_key", 32'(sig_out), 32'd1);
        tick();
        check("abort_ready", 32'(key_ready), 32'd1);
        check("abort_new_key_ff", 32'(sig_out), 32'd0);
        set_io(8'hC3, 4'h5);
        check("abort_new_key_c3", 32'(sig_out), 32'd0);
        check("abort_new_key_dout", 32'(d_out), 32'h5);

        // Reset in the middle of a load restores the default key.
        start_load();
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_io(8'h00, 4'h9);
        check("midrst_ready", 32'(key_ready), 32'd1);
        check("midrst_busy", 32'(key_busy), 32'd0);
        check("midrst_loaded", 32'(key_loaded), 32'd0);
        check("midrst_sig", 32'(sig_out), 32'd1);
        check("midrst_dout", 32'(d_out), 32'h6);

        // Gaps during load; stray valid/start in IDLE and COMMIT are ignored.
        send_bit(1'b1);
        send_bit(1'b1);
        check("idle_valid_ready", 32'(key_ready), 32'd1);
        start_load();
        for (int i = 0; i < 16; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
            if (i < 15) begin
                send_bit((16'hF00F >> i) & 16'h1);
            end else begin
                send_bit(1'b1);
            end
            if (i == 14) begin
                check("gap_15_busy", 32'(key_busy), 32'd1);
                check("gap_15_old_key", 32'(sig_out), 32'd1);
            end
        end
        // Now in COMMIT: hold stray start and valid for this one cycle.
        check("gap_commit_loaded", 32'(key_loaded), 32'd0);
        key_start = 1'b1; key_valid = 1'b1; key_bit = 1'b1;
        tick();
        key_start = 1'b0; key_valid = 1'b0; key_bit = 1'b0;
        check("gap_post_ready", 32'(key_ready), 32'd1);
        check("gap_post_busy", 32'(key_busy), 32'd0);
        check("gap_post_loaded", 32'(key_loaded), 32'd1);
        set_io(8'hF0, 4'h1);
        check("gap_key_f0_sig", 32'(sig_out), 32'd1);
        check("gap_key_f0_dout", 32'(d_out), 32'hE);
        set_io(8'h0F, 4'h1);
        check("gap_key_0f_sig", 32'(sig_out), 32'd0);
        set_io(8'h00, 4'h1);
        check("gap_key_00_sig", 32'(sig_out), 32'd0);
        tick();
        check("gap_idle_stays", 32'(key_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
